// File: rtl/adder5_arbiter.sv
// Two-requester round-robin front end sharing one WIDTH-bit adder, with a
// single registered result slot and a count of consumed results.
module adder5_arbiter #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] op_count
);

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic             id;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } rsp_t;

  req_t [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;

  logic             last_grant_q, last_grant_d;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             can_accept;
  logic             accept;
  logic             drain;
  logic             sel;
  req_t             req_sel;
  logic [WIDTH:0]   sum_full;

  assign req_vld = {req1_valid, req0_valid};
  assign req[0]  = {req0_a, req0_b};
  assign req[1]  = {req1_a, req1_b};

  // Slot is free when empty or when its current result leaves this edge.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // A lone requester always wins; on a tie the one not served last wins.
  // Ready is forced low while reset is held.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    localparam logic ID = 1'(i);
    assign grant[i] = req_vld[i] && (!req_vld[1-i] || (last_grant_q != ID));
    assign ready[i] = rst_n && can_accept && grant[i];
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  assign accept  = |ready;
  assign drain   = rsp_valid_q && rsp_ready;
  assign sel     = ready[1];
  assign req_sel = req[sel];

  // Single shared adder, one bit wider to expose the carry.
  assign sum_full = {1'b0, req_sel.a} + {1'b0, req_sel.b};

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_d        = rsp_q;
    rsp_valid_d  = rsp_valid_q;
    op_count_d   = op_count_q;
    if (drain) begin
      op_count_d  = op_count_q + 1'b1;
      rsp_valid_d = 1'b0;
    end
    if (accept) begin
      last_grant_d = sel;
      rsp_d.id     = sel;
      rsp_d.carry  = sum_full[WIDTH];
      rsp_d.sum    = sum_full[WIDTH-1:0];
      rsp_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= rsp_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_carry = rsp_q.carry;
  assign rsp_sum   = rsp_q.sum;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder5_arbiter.sv
// Self-checking bench for adder5_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level model of the arbiter.
module tb_adder5_arbiter;
  localparam int WIDTH = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_carry;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_sum;
  logic [CNT_W-1:0] op_count;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic             m_valid, m_id, m_carry, m_last;
  logic [WIDTH-1:0] m_sum;
  logic [CNT_W-1:0] m_cnt;

  adder5_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int g;
    g = exp_grant();
    if (!rst_n || (m_valid && !rsp_ready) || g < 0) return 2'b00;
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] exp_out();
    return {m_valid, m_id, m_carry, m_sum, m_cnt};
  endfunction

  function automatic logic [15:0] dut_out();
    return {rsp_valid, rsp_id, rsp_carry, rsp_sum, op_count};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_carry = 1'b0; m_sum = '0; m_cnt = '0; m_last = 1'b1;
  endtask

  task automatic drive(input logic v0, input int a0, input int b0,
                       input logic v1, input int a1, input int b1, input logic rr);
    req0_valid = v0; req0_a = WIDTH'(a0); req0_b = WIDTH'(b0);
    req1_valid = v1; req1_a = WIDTH'(a1); req1_b = WIDTH'(b1);
    rsp_ready  = rr;
  endtask

  // One clock: predict from the inputs present now, then advance the model.
  task automatic step();
    int g, s;
    logic acc, drn;
    g   = exp_grant();
    acc = (g >= 0) && (!m_valid || rsp_ready) && rst_n;
    drn = m_valid && rsp_ready && rst_n;
    s   = (g == 1) ? int'(req1_a) + int'(req1_b) : int'(req0_a) + int'(req0_b);
    @(posedge clk);
    if (drn) m_cnt = m_cnt + 1'b1;
    if (acc) begin
      m_sum = WIDTH'(s % 32); m_carry = (s / 32) != 0;
      m_id = (g == 1); m_last = (g == 1); m_valid = 1'b1;
    end else if (drn) m_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 2, 1, 3, 4, 1);
    model_reset();
    #1;
    vectors++;
    if (dut_out() !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_out(), 16'h0);
    end
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    drive(1, 3, 4, 0, 0, 0, 1);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready});
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b0, 1'b0, 5'd7}) begin
      errors++; $display("FAIL single_result got=%b exp=%b",
        {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 1'b0, 1'b0, 5'd7});
    end
    step();
    vectors++;
    if ({rsp_valid, op_count} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL single_drain got=%b/%0d exp=0/1", rsp_valid, op_count);
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 1, 31, 1, 1);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL ovf_ready got=%b exp=10", {req1_ready, req0_ready});
    end
    step();
    drive(0, 0, 0, 1, 31, 31, 1);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b1, 1'b1, 5'd0}) begin
      errors++; $display("FAIL ovf_31p1 got=%b exp=%b",
        {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 1'b1, 1'b1, 5'd0});
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b1, 1'b1, 5'd30}) begin
      errors++; $display("FAIL ovf_31p31 got=%b exp=%b",
        {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 1'b1, 1'b1, 5'd30});
    end
    step();
    vectors++;
    if (dut_out() !== exp_out()) begin
      errors++; $display("FAIL ovf_drain got=%h exp=%h", dut_out(), exp_out());
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31),
            1, $urandom_range(0, 31), $urandom_range(0, 31), 1);
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_ready[%0d] got=%b", i, {req1_ready, req0_ready});
      end
      step();
      vectors++;
      if ({rsp_valid, rsp_id, op_count} !== {1'b1, 1'(i % 2), 8'(i)}) begin
        errors++; $display("FAIL rr_result[%0d] got=%b/%b/%0d exp=1/%0d/%0d",
          i, rsp_valid, rsp_id, op_count, i % 2, i);
      end
      vectors++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL rr_model[%0d] got=%h exp=%h", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_backpressure();
    logic prev_last;
    logic [15:0] held;
    held = exp_out();
    drive(1, $urandom_range(0, 31), $urandom_range(0, 31),
          1, $urandom_range(0, 31), $urandom_range(0, 31), 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req1_ready, req0_ready});
      end
      step();
      vectors++;
      if (dut_out() !== held) begin
        errors++; $display("FAIL bp_stable[%0d] got=%h exp=%h", i, dut_out(), held);
      end
    end
    prev_last = m_last;
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== (prev_last ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL bp_release_ready got=%b", {req1_ready, req0_ready});
    end
    step();
    vectors++;
    if ({rsp_valid, rsp_id, op_count} !== {1'b1, !prev_last, held[7:0] + 8'd1}) begin
      errors++; $display("FAIL bp_release got=%b/%b/%0d", rsp_valid, rsp_id, op_count);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 5, 6, 1, 7, 8, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_out() !== 16'h0 || {req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL rstmid_async got=%h/%b exp=0/00", dut_out(), {req1_ready, req0_ready});
    end
    @(posedge clk);
    #1;
    vectors++;
    if (dut_out() !== 16'h0) begin
      errors++; $display("FAIL rstmid_hold got=%h exp=0", dut_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid_tie got=%b exp=01", {req1_ready, req0_ready});
    end
    step();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum, op_count} !== {1'b1, 1'b0, 1'b0, 5'd11, 8'd0}) begin
      errors++; $display("FAIL rstmid_first got=%h", dut_out());
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 1; k <= 257; k++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0, 1);
      step();
      if (k == 256) begin
        vectors++;
        if (op_count !== 8'd255) begin
          errors++; $display("FAIL wrap_255 got=%0d exp=255", op_count);
        end
      end
    end
    vectors++;
    if ({rsp_valid, op_count} !== {1'b1, 8'd0} || dut_out() !== exp_out()) begin
      errors++; $display("FAIL wrap_zero got=%h exp=%h", dut_out(), exp_out());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== exp_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, exp_ready());
      end
      step();
      vectors++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, dut_out(), exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adder5_arbiter.md
ADDER5_ARBITER -- requirements
Module: adder5_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, operand/sum width of the shared adder.
REQ-002 Parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 Port: req1_valid, req1_a, req1_b, req1_ready  as REQ-005..007, for requester 1.
REQ-009 Port: rsp_valid  output  1  result register holds a valid result.
REQ-010 Port: rsp_ready  input  1  consumer accepts the result.
REQ-011 Port: rsp_id  output  1  requester that issued the result (0 or 1).
REQ-012 Port: rsp_sum  output  WIDTH  low WIDTH bits of a+b.
REQ-013 Port: rsp_carry  output  1  bit WIDTH of a+b (carry out).
REQ-014 Port: op_count  output  CNT_W  number of results consumed by rsp handshake.

Function
REQ-015 One shared WIDTH-bit adder; exactly one operand pair enters it per accepting cycle.
REQ-016 Transfer on requester side: reqX_valid && reqX_ready at a rising edge; on response side: rsp_valid && rsp_ready.
REQ-017 can_accept = !rsp_valid || rsp_ready (combinational; output register empty or draining this cycle).
REQ-018 Grant is combinational: if only one requester valid, grant it; if both valid, grant the one not equal to last_grant; if none valid, no grant.
REQ-019 reqX_ready = can_accept && grant==X; at most one ready high per cycle; ready never depends on the same requester's operand values.
REQ-020 last_grant updates to X only on an accepted transfer from X; holds otherwise.
REQ-021 On accepted transfer: rsp_sum <= (a+b)[WIDTH-1:0], rsp_carry <= (a+b)[WIDTH] computed at WIDTH+1 bits, rsp_id <= X, rsp_valid <= 1; latency exactly 1 cycle.
REQ-022 Simultaneous drain and accept: new result replaces old in the same edge, rsp_valid stays 1; throughput one result per cycle.
REQ-023 Drain with no accept: rsp_valid <= 0; rsp_sum/rsp_carry/rsp_id hold last values.
REQ-024 Backpressure: while rsp_valid && !rsp_ready, both readies are 0 and rsp_* outputs are stable.
REQ-025 Fairness: with both requesters continuously valid and rsp_ready=1, grants strictly alternate; no requester waits more than one accepted transfer.
REQ-026 op_count increments by 1 on each response transfer; wraps from 2^CNT_W-1 to 0.
REQ-027 Requesters may drop valid without a transfer; block holds no state for unaccepted requests.

Reset
REQ-028 rst_n low asynchronously forces: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, op_count=0, last_grant=1 (so requester 0 wins first tie).
REQ-029 While rst_n low, req0_ready and req1_ready are 0.
REQ-030 Reset asserted mid-operation discards the held result without a response transfer; op_count does not count it.
REQ-031 First accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Single: req0 a=5'd3,b=5'd4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=7, rsp_carry=0; op_count=1 after drain.
REQ-033 Overflow: req1 a=5'd31,b=5'd1 -> rsp_sum=0, rsp_carry=1, rsp_id=1; a=31,b=31 -> sum=30, carry=1.
REQ-034 Tie/round-robin: both valid continuously after reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1,...; one result per cycle, op_count increments each cycle.
REQ-035 Backpressure: result held, rsp_ready=0 for 3 cycles with both requesters valid -> both readies 0, rsp_* stable; on rsp_ready=1, drain and accept in same edge, next requester per last_grant.
REQ-036 Reset mid-stream: rst_n low while rsp_valid=1 -> all outputs to reset values immediately (no clock edge); after release, first tie grants requester 0.
REQ-037 Wrap: 256 consumed results with CNT_W=8 -> op_count returns to 0.
